// File: rtl/inst_fetch_unit.sv
// Instruction fetch: holds the PC, issues one memory request at a time
// and hands fetched words to decode over a valid/ready handshake.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              discard;
  logic [ADDR_W-1:0] target;

  assign target    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  // Fetch sequencing; a redirect overrides every other event outside IDLE.
  // discard marks the single in-flight response as wrong-path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      discard     <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= NOP;
      inst_pc     <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (redirect) begin
            pc         <= target;
            inst_valid <= 1'b0;
            if (imem_ready) begin
              discard <= 1'b1;
              state   <= S_WAIT;
            end
          end else if (imem_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc         <= target;
            inst_valid <= 1'b0;
            if (imem_rvalid) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              discard <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + ADDR_W'(4);
              state      <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (redirect) begin
            pc         <= target;
            inst_valid <= 1'b0;
            state      <= S_REQ;
          end else if (inst_ready) begin
            inst_valid  <= 1'b0;
            fetch_count <= fetch_count + 32'd1;
            state       <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
